comparator_arbiter: RTL and testbench

- Shares the single 8-bit Comparator datapath (ports A, B, Y) of the mini CPU between NUM_REQ requesters, e.g. branch unit, ALU flag logic and debug port.
- Round-robin arbitration; one operation in flight at a time.
- Operands are registered into the Comparator, the result Y is captured, and it is returned with the requester ID over a valid/ready response channel.
- Y is treated as an opaque 8-bit result; the block does not interpret it.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/comparator.sv | 18 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/comparator_arbiter.sv | 149 ++++++++++++++
 tb/tb_comparator_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU comparator-sharing logic:
// datapath width, arbiter state encoding and the packed-operand slice helper.
package cpu_pkg;

  localparam int DATA_W  = 8;
  localparam int MAX_REQ = 8;

  // 2'd3 is unused and the next-state logic sends it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Extracts requester idx's operand from a bus padded to MAX_REQ slots.
  function automatic logic [DATA_W-1:0] op_slice(
    input logic [MAX_REQ*DATA_W-1:0] vec,
    input int unsigned               idx
  );
    return vec[idx*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/comparator.sv
// Mini CPU 8-bit Comparator datapath: Y = {5'b0, A>B, A==B, A<B}.
// Purely combinational; the arbiter registers its inputs and captures Y.
module comparator
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Y
);

  always_comb begin
    Y    = '0;
    Y[0] = (A < B);
    Y[1] = (A == B);
    Y[2] = (A > B);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ. Produces one-hot grant, its index and a hit flag.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_grant
);

  int unsigned cand;

  always_comb begin
    // NOTE: every output and temporary gets a default before the search loop,
    // so no path leaves a value unassigned and no latch is inferred.
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (en && !any_grant && req[cand]) begin
        any_grant   = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/comparator_arbiter.sv
// Shares the single Comparator between NUM_REQ requesters: round-robin accept,
// registered operands, one operation in flight, valid/ready response with ID.
module comparator_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_y,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (DATA_W != cpu_pkg::DATA_W || (2 ** ID_W) < NUM_REQ || NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_param_check
    $error("comparator_arbiter: illegal NUM_REQ/DATA_W/ID_W combination");
  end

  arb_state_e                state_q, state_d;
  logic [DATA_W-1:0]         op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DATA_W-1:0]         rsp_y_q, rsp_y_d, cmp_y;
  logic [ID_W-1:0]           id_q, id_d, rsp_id_q, rsp_id_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d, win_idx;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      arb_en, any_grant;
  logic [NUM_REQ-1:0]        grant;
  logic [MAX_REQ*DATA_W-1:0] req_a_ext, req_b_ext;

  always_comb begin
    req_a_ext = '0;
    req_b_ext = '0;
    req_a_ext[NUM_REQ*DATA_W-1:0] = req_a;
    req_b_ext[NUM_REQ*DATA_W-1:0] = req_b;
  end

  // Qualifying with rst_n keeps req_ready low while reset is held, even
  // though the state register already reads IDLE.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (PTR_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .idx       (win_idx),
    .any_grant (any_grant)
  );

  comparator u_comparator (
    .A (op_a_q),
    .B (op_b_q),
    .Y (cmp_y)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath register updates
  always_comb begin
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    case (state_q)
      IDLE: begin
        if (any_grant) begin
          op_a_d = op_slice(req_a_ext, 32'(win_idx));
          op_b_d = op_slice(req_b_ext, 32'(win_idx));
          id_d   = ID_W'(win_idx);
          ptr_d  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      EXEC: begin
        rsp_y_d     = cmp_y;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: rsp_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
    end else begin
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
    end
  end

  // Output logic
  always_comb begin
    req_ready = grant;
    rsp_valid = rsp_valid_q;
    rsp_id    = rsp_id_q;
    rsp_y     = rsp_y_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed self-checking bench for comparator_arbiter (NUM_REQ=4).
// Expected Comparator Y: bit0 A<B, bit1 A==B, bit2 A>B.
module tb_comparator_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_y;
  logic                      busy;

  int n_checks = 0;
  int n_fail   = 0;

  comparator_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
    req_a[idx*DATA_W +: DATA_W] = a;
    req_b[idx*DATA_W +: DATA_W] = b;
  endtask

  // Operands 0..3: eq -> 02, lt -> 01, gt -> 04, eq -> 02
  task automatic load_default_ops();
    set_ops(0, 8'h05, 8'h05);
    set_ops(1, 8'h10, 8'h20);
    set_ops(2, 8'h20, 8'h10);
    set_ops(3, 8'h30, 8'h30);
  endtask

  logic [7:0] y_tab [NUM_REQ];

  initial begin
    y_tab[0] = 8'h02; y_tab[1] = 8'h01; y_tab[2] = 8'h04; y_tab[3] = 8'h02;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    load_default_ops();

    // Reset held with every requester valid
    repeat (3) step();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id",    32'(rsp_id),    32'h0);
    check("rst_rsp_y",     32'(rsp_y),     32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_first_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("rst_exec_busy",  32'(busy),      32'h1);
    check("rst_exec_valid", 32'(rsp_valid), 32'h0);
    step();
    check("rst_rsp_valid1", 32'(rsp_valid), 32'h1);
    check("rst_rsp_id0",    32'(rsp_id),    32'h0);
    check("rst_rsp_y0",     32'(rsp_y),     32'h02);
    rsp_ready = 1'b1;
    step();
    check("rst_done_valid", 32'(rsp_valid), 32'h0);

    // Single request from requester 1 with (1,0): A>B -> 04
    set_ops(1, 8'h01, 8'h00);
    req_valid = 4'b0010;
    #1;
    check("single_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    check("single_pulse_once", 32'(req_ready), 32'h0);
    check("single_exec_valid", 32'(rsp_valid), 32'h0);
    step();
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_id",    32'(rsp_id),    32'h1);
    check("single_y",     32'(rsp_y),     32'h04);
    step();
    check("single_done_valid", 32'(rsp_valid), 32'h0);
    check("single_done_busy",  32'(busy),      32'h0);

    // Pulse reset to bring ptr back to 0 for the fairness sequence
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    load_default_ops();

    // Round-robin: all valid, rsp_ready=1 -> grants 0,1,2,3,0 every 3 cycles
    req_valid = '1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_grant%0d", i), 32'(req_ready), 32'(1 << (i % NUM_REQ)));
      step();
      if (i == 4) req_valid = '0;
      check($sformatf("rr_gap_a%0d", i), 32'(req_ready), 32'h0);
      step();
      check($sformatf("rr_gap_b%0d", i), 32'(req_ready), 32'h0);
      check($sformatf("rr_id%0d", i), 32'(rsp_id), 32'(i % NUM_REQ));
      check($sformatf("rr_y%0d", i),  32'(rsp_y),  32'(y_tab[i % NUM_REQ]));
      step();
    end

    // Backpressure: ptr=1, all valid, consumer stalls 5 cycles
    rsp_ready = 1'b0;
    req_valid = '1;
    #1;
    check("bp_grant1", 32'(req_ready), 32'h2);
    step();
    step();
    check("bp_valid_rise", 32'(rsp_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'h1);
      check($sformatf("bp_id%0d", i),    32'(rsp_id),    32'h1);
      check($sformatf("bp_y%0d", i),     32'(rsp_y),     32'h01);
      check($sformatf("bp_busy%0d", i),  32'(busy),      32'h1);
      check($sformatf("bp_noready%0d", i), 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_idle_busy",  32'(busy),      32'h0);
    check("bp_idle_valid", 32'(rsp_valid), 32'h0);
    check("bp_next_grant", 32'(req_ready), 32'h4);
    step();
    // Requester 2 granted (ptr -> 3); requester 3 withdraws
    req_valid = 4'b0011;
    check("bp_next_busy", 32'(busy), 32'h1);
    step();
    check("wrap_id2", 32'(rsp_id), 32'h2);
    check("wrap_y2",  32'(rsp_y),  32'h04);
    step();
    check("wrap_grant0", 32'(req_ready), 32'h1);
    step();
    // Operands change after grant: original (05,05) -> 02, new would give 01
    set_ops(0, 8'h00, 8'hFF);
    req_valid = '0;
    step();
    check("late_op_id", 32'(rsp_id), 32'h0);
    check("late_op_y",  32'(rsp_y),  32'h02);
    step();

    // Async reset while in EXEC
    req_valid = 4'b0100;
    #1;
    check("ar_grant2", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    check("ar_exec_busy", 32'(busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy",      32'(busy),      32'h0);
    check("ar_req_ready", 32'(req_ready), 32'h0);
    check("ar_rsp_valid", 32'(rsp_valid), 32'h0);
    check("ar_rsp_y",     32'(rsp_y),     32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("ar_no_rsp%0d", i), 32'(rsp_valid), 32'h0);
    end
    check("ar_final_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
